id_ex_pipe_reg: RTL
===================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the pipelined RV32I core, sitting between the decode stage and the execute stage. It captures the decode-stage datapath and control fields each cycle. It also adds what the first-generation stage register lacked: stall (hold), flush (bubble insertion), a per-stage valid bit, and forwarding of source-register addresses to the hazard unit. Optional performance counters record stall and bubble cycles.

## Interface
- DATA_WIDTH, 32, width of operand, PC and immediate fields
- REG_ADDR_WIDTH, 5, register-file address width
- ALU_CTRL_WIDTH, 4, ALU control width (widened from 3 to cover SLT/SLTU/SRA)
- RESULT_SRC_WIDTH, 2, result-mux select width
- CNT_WIDTH, 32, performance counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- StallE  in  1  hold all E outputs this cycle
- FlushE  in  1  replace the E contents with a bubble this cycle
- ValidD  in  1  decode stage holds a real instruction
- Rd1D, Rd2D, PCD, PCPlus4D, ImmExtD  in  DATA_WIDTH each  register-file operands, PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH each  source and destination register addresses
- Funct3D  in  3  branch/load/store sub-op
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  control bits
- ResultSrcD  in  RESULT_SRC_WIDTH  result select
- ALUControlD  in  ALU_CTRL_WIDTH  ALU op
- Outputs Rd1E, Rd2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, Funct3E, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE  out  same widths as the matching D inputs  registered E-stage copies
- ValidE  out  1  E stage holds a real instruction
- StallCnt, BubbleCnt  out  CNT_WIDTH each  present only with PIPE_PERF_CNT_EN

## Operation
- The next state is chosen by fixed priority: rst > FlushE > StallE > load.
- rst: all outputs go to 0, including ValidE and the counters.
- FlushE: ValidE is 0 and every output field is 0. The bubble is therefore a NOP with no architectural effect: RegWriteE, MemWriteE, JumpE and BranchE are all 0, and RdE is x0.
- StallE (without FlushE): every register holds its value, including ValidE.
- Load: every E output takes its D input, and ValidE is set to ValidD.
- ValidD=0 with no stall and no flush: the fields load as normal, but the control bits RegWriteE, MemWriteE, JumpE and BranchE are forced to 0. An invalid slot must never write state.
- The fields are fully independent. Every one of them is captured, including JumpE and every bit of Rs1/Rs2, so the hazard unit sees the E-stage sources.

## Timing
- Latency is 1 cycle from D inputs to E outputs in the load case.
- All outputs are registered, with no combinational path from inputs to outputs.
- FlushE and StallE are sampled on the same edge as the data. Their effect is visible in the cycle after they are asserted.
- FlushE together with StallE: the flush wins, and the bubble is visible next cycle.
- rst asserted during a stall or flush: reset values apply next cycle.
- Outputs are 0 after reset until the first load.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - StallCnt increments on each cycle with StallE=1 and FlushE=0.
  - BubbleCnt increments on each cycle the E register loads a bubble. This covers FlushE=1, and also a load with ValidD=0.
  - Both counters saturate at all-ones and do not wrap.
  - Both counters are cleared by rst.
- PIPE_PERF_CNT_EN undefined: the StallCnt and BubbleCnt ports and their logic are absent. All other behaviour is identical.

## Structure
- The shared package pipe_pkg holds:
  - result-source encodings: RES_ALU=0, RES_MEM=1, RES_PC4=2
  - the ALU control enum
  - a packed struct id_ex_ctrl_t covering RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl and ALUSrc
  - the default parameter constants
- One natural sub-module is pipe_stage_reg. It is a generic WIDTH-parametrised register with rst/flush/stall/load priority and a configurable flush value. It is instantiated once for the data bundle and once for the control bundle plus valid.

## Test plan
- Reset: assert rst for 2 cycles with all D inputs=1s -> all E outputs and ValidE = 0.
- Load: PCD=0x100, Rd1D=0xDEADBEEF, RdD=5, RegWriteD=1, ValidD=1 -> next cycle PCE=0x100, Rd1E=0xDEADBEEF, RdE=5, RegWriteE=1, ValidE=1.
- Stall: after the load above, StallE=1 for 3 cycles with PCD=0x200 -> PCE stays 0x100 and ValidE stays 1; then StallE=0 -> PCE=0x200.
- Flush over stall: StallE=1, FlushE=1, MemWriteD=1 -> next cycle ValidE=0, MemWriteE=0, RdE=0, PCE=0.
- Invalid slot: ValidD=0, RegWriteD=1, BranchD=1, PCD=0x300 -> ValidE=0, RegWriteE=0, BranchE=0, PCE=0x300.
- Counters (with PIPE_PERF_CNT_EN, CNT_WIDTH=4): run 20 stall cycles -> StallCnt=15 and held; 2 flushes -> BubbleCnt=2; rst -> both 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline stage registers: default widths,
// result-source and ALU-op encodings, and the ID/EX control bundle layout.
package pipe_pkg;

  localparam int DATA_WIDTH_DEF       = 32;
  localparam int REG_ADDR_WIDTH_DEF   = 5;
  localparam int ALU_CTRL_WIDTH_DEF   = 4;
  localparam int RESULT_SRC_WIDTH_DEF = 2;
  localparam int CNT_WIDTH_DEF        = 32;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_e   alu_control;
    logic        alu_src;
  } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with fixed priority rst > flush > stall > load;
// flush loads FLUSH_VAL, reset always clears to zero.
module pipe_stage_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= FLUSH_VAL;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and valid tracking.
// Define PIPE_PERF_CNT_EN to add the saturating StallCnt/BubbleCnt counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
  parameter int ALU_CTRL_WIDTH   = ALU_CTRL_WIDTH_DEF,
  parameter int RESULT_SRC_WIDTH = RESULT_SRC_WIDTH_DEF,
  parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        StallE,
  input  logic                        FlushE,
  input  logic                        ValidD,
  input  logic [DATA_WIDTH-1:0]       Rd1D,
  input  logic [DATA_WIDTH-1:0]       Rd2D,
  input  logic [DATA_WIDTH-1:0]       PCD,
  input  logic [DATA_WIDTH-1:0]       PCPlus4D,
  input  logic [DATA_WIDTH-1:0]       ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0]   Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0]   Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0]   RdD,
  input  logic [2:0]                  Funct3D,
  input  logic                        RegWriteD,
  input  logic                        MemWriteD,
  input  logic                        JumpD,
  input  logic                        BranchD,
  input  logic                        ALUSrcD,
  input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcD,
  input  logic [ALU_CTRL_WIDTH-1:0]   ALUControlD,
  output logic [DATA_WIDTH-1:0]       Rd1E,
  output logic [DATA_WIDTH-1:0]       Rd2E,
  output logic [DATA_WIDTH-1:0]       PCE,
  output logic [DATA_WIDTH-1:0]       PCPlus4E,
  output logic [DATA_WIDTH-1:0]       ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0]   Rs1E,
  output logic [REG_ADDR_WIDTH-1:0]   Rs2E,
  output logic [REG_ADDR_WIDTH-1:0]   RdE,
  output logic [2:0]                  Funct3E,
  output logic                        RegWriteE,
  output logic                        MemWriteE,
  output logic                        JumpE,
  output logic                        BranchE,
  output logic                        ALUSrcE,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
  output logic [ALU_CTRL_WIDTH-1:0]   ALUControlE,
  output logic                        ValidE
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]        StallCnt,
  output logic [CNT_WIDTH-1:0]        BubbleCnt
`endif
);

  localparam int DW = 5 * DATA_WIDTH + 3 * REG_ADDR_WIDTH + 3;
  localparam int CW = 6 + RESULT_SRC_WIDTH + ALU_CTRL_WIDTH;

  logic [DW-1:0] data_d_p0, data_q_p1;
  logic [CW-1:0] ctrl_d_p0, ctrl_q_p1;

  assign data_d_p0 = {Rd1D, Rd2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD, Funct3D};

  // State-changing controls are gated by ValidD so an empty slot can never commit.
  assign ctrl_d_p0 = {ValidD,
                      RegWriteD & ValidD,
                      MemWriteD & ValidD,
                      JumpD & ValidD,
                      BranchD & ValidD,
                      ALUSrcD, ResultSrcD, ALUControlD};

  pipe_stage_reg #(.WIDTH(DW), .FLUSH_VAL('0)) u_data_reg (
    .clk   (clk),
    .rst   (rst),
    .flush (FlushE),
    .stall (StallE),
    .d     (data_d_p0),
    .q     (data_q_p1)
  );

  pipe_stage_reg #(.WIDTH(CW), .FLUSH_VAL('0)) u_ctrl_reg (
    .clk   (clk),
    .rst   (rst),
    .flush (FlushE),
    .stall (StallE),
    .d     (ctrl_d_p0),
    .q     (ctrl_q_p1)
  );

  // ---- E stage outputs ----
  assign {Rd1E, Rd2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, Funct3E} = data_q_p1;
  assign {ValidE, RegWriteE, MemWriteE, JumpE, BranchE,
          ALUSrcE, ResultSrcE, ALUControlE} = ctrl_q_p1;

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic stall_evt, bubble_evt;
  assign stall_evt  = StallE & ~FlushE;
  assign bubble_evt = FlushE | (~StallE & ~ValidD);

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (stall_evt)  StallCnt  <= sat_inc(StallCnt);
      if (bubble_evt) BubbleCnt <= sat_inc(BubbleCnt);
    end
  end
`endif

endmodule
